alu_seq_8051: RTL and testbench

Sequenced 8051 ALU stage that sits directly upstream of the accumulator register. It computes the new accumulator value and drives the accumulator's load strobe, plus B and PSW flag write-backs. Most ops are single-cycle; MUL AB and DIV AB are iterative over 8 cycles. A start/busy/done handshake lets the control unit issue one operation at a time.

---
 rtl/alu_seq_8051_if.sv | 44 ++++
 rtl/alu_seq_8051.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_seq_8051.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_8051_if.sv
// ---------------------------------------------------------------------------
// alu_seq_8051_if
// Bus between the 8051 control unit and the sequenced ALU stage.
//   master (control unit): drives start, op, a_in, b_in, cy_in;
//                          receives busy/done handshake and write-back results.
//   slave  (ALU stage)   : the mirror image.
// Signals:
//   start, op[3:0], a_in, b_in, cy_in       -- issue request and operands
//   busy, done                              -- handshake
//   set_acc, value                          -- accumulator write-back
//   set_b, b_out                            -- B register write-back
//   cy_out, ac_out, ov_out, flag_we[2:0]    -- PSW flags, enables {cy,ac,ov}
// ---------------------------------------------------------------------------
interface alu_seq_8051_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cy_in;
  logic             busy;
  logic             done;
  logic             set_acc;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] b_out;
  logic             set_b;
  logic             cy_out;
  logic             ac_out;
  logic             ov_out;
  logic [2:0]       flag_we;

  modport master (
    output start, op, a_in, b_in, cy_in,
    input  busy, done, set_acc, value, b_out, set_b,
           cy_out, ac_out, ov_out, flag_we
  );

  modport slave (
    input  start, op, a_in, b_in, cy_in,
    output busy, done, set_acc, value, b_out, set_b,
           cy_out, ac_out, ov_out, flag_we
  );
endinterface

// File: rtl/alu_seq_8051.sv
// ---------------------------------------------------------------------------
// alu_seq_8051
// Sequenced 8051 ALU stage feeding the accumulator. Single-cycle ops finish
// one cycle after the start is sampled; MUL AB and DIV AB iterate one bit per
// cycle for ITER cycles and finish nine cycles after the start.
// Ports:
//   clk  -- rising-edge clock
//   rst  -- asynchronous reset, active-low
//   bus  -- alu_seq_8051_if.slave: start/op/operands in, handshake and
//           accumulator/B/PSW write-back out
// ---------------------------------------------------------------------------
module alu_seq_8051 #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_seq_8051_if.slave       bus
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_SUBB = 4'h2;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_ANL  = 4'h5;
  localparam logic [3:0] OP_ORL  = 4'h6;
  localparam logic [3:0] OP_XRL  = 4'h7;
  localparam logic [3:0] OP_CPL  = 4'h8;
  localparam logic [3:0] OP_RL   = 4'h9;
  localparam logic [3:0] OP_RR   = 4'hA;
  localparam logic [3:0] OP_RLC  = 4'hB;
  localparam logic [3:0] OP_RRC  = 4'hC;
  localparam logic [3:0] OP_SWAP = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_DIV  = 4'hF;

  localparam logic [2:0]       CNT_INIT = 3'(ITER - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   is_mul_q, is_mul_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]       value_q, value_d;
  logic [WIDTH-1:0]       bout_q, bout_d;
  logic                   cy_q, cy_d;
  logic                   ac_q, ac_d;
  logic                   ov_q, ov_d;
  logic [2:0]             fwe_q, fwe_d;
  logic                   setb_q, setb_d;

  // Single-cycle datapath, evaluated straight from the request operands
  logic                   cin_add;
  logic [WIDTH:0]         add9, sub9;
  logic [4:0]             add_lo, sub_lo;
  logic [7:0]             add_hi7, sub_hi7;
  logic [WIDTH-1:0]       sc_value, sc_bout;
  logic                   sc_cy, sc_ac, sc_ov, sc_setb;
  logic [2:0]             sc_fwe;

  assign cin_add = (bus.op == OP_ADDC) ? bus.cy_in : 1'b0;
  assign add9    = {1'b0, bus.a_in} + {1'b0, bus.b_in} + {{WIDTH{1'b0}}, cin_add};
  assign add_lo  = {1'b0, bus.a_in[3:0]} + {1'b0, bus.b_in[3:0]} + {4'b0, cin_add};
  assign add_hi7 = {1'b0, bus.a_in[6:0]} + {1'b0, bus.b_in[6:0]} + {7'b0, cin_add};
  // Top bit of each widened difference is the borrow out of that slice
  assign sub9    = {1'b0, bus.a_in} - {1'b0, bus.b_in} - {{WIDTH{1'b0}}, bus.cy_in};
  assign sub_lo  = {1'b0, bus.a_in[3:0]} - {1'b0, bus.b_in[3:0]} - {4'b0, bus.cy_in};
  assign sub_hi7 = {1'b0, bus.a_in[6:0]} - {1'b0, bus.b_in[6:0]} - {7'b0, bus.cy_in};

  always_comb begin
    sc_value = bus.a_in;
    sc_bout  = bus.b_in;
    sc_cy    = 1'b0;
    sc_ac    = 1'b0;
    sc_ov    = 1'b0;
    sc_fwe   = 3'b000;
    sc_setb  = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADDC: begin
        sc_value = add9[WIDTH-1:0];
        sc_cy    = add9[WIDTH];
        sc_ac    = add_lo[4];
        sc_ov    = add_hi7[7] ^ add9[WIDTH];
        sc_fwe   = 3'b111;
      end
      OP_SUBB: begin
        sc_value = sub9[WIDTH-1:0];
        sc_cy    = sub9[WIDTH];
        sc_ac    = sub_lo[4];
        sc_ov    = sub_hi7[7] ^ sub9[WIDTH];
        sc_fwe   = 3'b111;
      end
      OP_INC:  sc_value = bus.a_in + ONE;
      OP_DEC:  sc_value = bus.a_in - ONE;
      OP_ANL:  sc_value = bus.a_in & bus.b_in;
      OP_ORL:  sc_value = bus.a_in | bus.b_in;
      OP_XRL:  sc_value = bus.a_in ^ bus.b_in;
      OP_CPL:  sc_value = ~bus.a_in;
      OP_RL:   sc_value = {bus.a_in[WIDTH-2:0], bus.a_in[WIDTH-1]};
      OP_RR:   sc_value = {bus.a_in[0], bus.a_in[WIDTH-1:1]};
      OP_RLC: begin
        sc_value = {bus.a_in[WIDTH-2:0], bus.cy_in};
        sc_cy    = bus.a_in[WIDTH-1];
        sc_fwe   = 3'b100;
      end
      OP_RRC: begin
        sc_value = {bus.cy_in, bus.a_in[WIDTH-1:1]};
        sc_cy    = bus.a_in[0];
        sc_fwe   = 3'b100;
      end
      OP_SWAP: sc_value = {bus.a_in[3:0], bus.a_in[7:4]};
      OP_DIV: begin
        // Only reached as a single-cycle op when the divisor is zero
        sc_ov   = 1'b1;
        sc_fwe  = 3'b101;
        sc_setb = 1'b1;
      end
      default: ;
    endcase
  end

  // Iterative datapath: one multiplier/dividend bit per cycle, MSB first
  logic [2*WIDTH-1:0]     mul_step, div_step;
  logic [WIDTH:0]         div_trial, div_diff;
  logic                   div_ge;
  logic [WIDTH-1:0]       quo_bit;

  assign mul_step  = {work_q[2*WIDTH-2:0], 1'b0}
                   + (b_q[cnt_q] ? {{WIDTH{1'b0}}, a_q} : {(2*WIDTH){1'b0}});
  // DIV keeps the partial remainder in the upper half, quotient in the lower
  assign div_trial = {work_q[2*WIDTH-1:WIDTH], a_q[cnt_q]};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  assign quo_bit   = ONE << cnt_q;
  assign div_step  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                      (work_q[WIDTH-1:0] | (div_ge ? quo_bit : {WIDTH{1'b0}}))};

  always_comb begin
    state_d  = state_q;
    is_mul_d = is_mul_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    value_d  = value_q;
    bout_d   = bout_q;
    cy_d     = cy_q;
    ac_d     = ac_q;
    ov_d     = ov_q;
    fwe_d    = fwe_q;
    setb_d   = setb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_mul_d = (bus.op == OP_MUL);
          a_d      = bus.a_in;
          b_d      = bus.b_in;
          cnt_d    = CNT_INIT;
          work_d   = '0;
          if ((bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b_in != '0))) begin
            state_d = S_ITER;
          end else begin
            state_d = S_DONE;
            value_d = sc_value;
            cy_d    = sc_cy;
            ac_d    = sc_ac;
            ov_d    = sc_ov;
            fwe_d   = sc_fwe;
            setb_d  = sc_setb;
            if (sc_setb) bout_d = sc_bout;
          end
        end
      end
      S_ITER: begin
        work_d = is_mul_q ? mul_step : div_step;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
          value_d = work_d[WIDTH-1:0];
          bout_d  = work_d[2*WIDTH-1:WIDTH];
          cy_d    = 1'b0;
          ac_d    = 1'b0;
          ov_d    = is_mul_q ? (|mul_step[2*WIDTH-1:WIDTH]) : 1'b0;
          fwe_d   = 3'b101;
          setb_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      is_mul_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      value_q  <= '0;
      bout_q   <= '0;
      cy_q     <= 1'b0;
      ac_q     <= 1'b0;
      ov_q     <= 1'b0;
      fwe_q    <= 3'b000;
      setb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_mul_q <= is_mul_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      value_q  <= value_d;
      bout_q   <= bout_d;
      cy_q     <= cy_d;
      ac_q     <= ac_d;
      ov_q     <= ov_d;
      fwe_q    <= fwe_d;
      setb_q   <= setb_d;
    end
  end

  // Write-back strobes are qualified by the DONE state so they pulse once
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.set_acc = (state_q == S_DONE);
  assign bus.set_b   = (state_q == S_DONE) & setb_q;
  assign bus.flag_we = (state_q == S_DONE) ? fwe_q : 3'b000;
  assign bus.value   = value_q;
  assign bus.b_out   = bout_q;
  assign bus.cy_out  = cy_q;
  assign bus.ac_out  = ac_q;
  assign bus.ov_out  = ov_q;

endmodule

// File: tb/tb_alu_seq_8051.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_8051
// Self-checking bench for alu_seq_8051: directed cases plus randomized
// operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq_8051;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_seq_8051_if bus ();

  alu_seq_8051 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] val;
    logic [7:0] bo;
    logic       cy;
    logic       ac;
    logic       ov;
    logic [2:0] fwe;
    logic       setb;
    logic [3:0] lat;
  } exp_t;

  function automatic int sgn8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference model: 8051 instruction semantics in plain integer arithmetic
  function automatic exp_t model(input int op, input int a, input int b, input int c);
    exp_t e;
    int s, cin;
    e = '0;
    e.lat = 4'd1;
    case (op)
      0, 1: begin
        cin   = (op == 1) ? c : 0;
        s     = a + b + cin;
        e.val = 8'(s % 256);
        e.cy  = (s > 255);
        e.ac  = ((a % 16) + (b % 16) + cin) > 15;
        s     = sgn8(a) + sgn8(b) + cin;
        e.ov  = (s > 127) || (s < -128);
        e.fwe = 3'b111;
      end
      2: begin
        s     = a - b - c;
        e.val = 8'((s + 256) % 256);
        e.cy  = (s < 0);
        e.ac  = ((a % 16) - (b % 16) - c) < 0;
        s     = sgn8(a) - sgn8(b) - c;
        e.ov  = (s > 127) || (s < -128);
        e.fwe = 3'b111;
      end
      3:  e.val = 8'((a + 1) % 256);
      4:  e.val = 8'((a + 255) % 256);
      5:  e.val = 8'(a & b);
      6:  e.val = 8'(a | b);
      7:  e.val = 8'(a ^ b);
      8:  e.val = 8'(255 - a);
      9:  e.val = 8'((a * 2) % 256 + a / 128);
      10: e.val = 8'(a / 2 + (a % 2) * 128);
      11: begin
        e.val = 8'((a * 2) % 256 + c);
        e.cy  = (a >= 128);
        e.fwe = 3'b100;
      end
      12: begin
        e.val = 8'(a / 2 + c * 128);
        e.cy  = (a % 2 == 1);
        e.fwe = 3'b100;
      end
      13: e.val = 8'((a % 16) * 16 + a / 16);
      14: begin
        s      = a * b;
        e.val  = 8'(s % 256);
        e.bo   = 8'(s / 256);
        e.ov   = (s > 255);
        e.fwe  = 3'b101;
        e.setb = 1'b1;
        e.lat  = 4'd9;
      end
      default: begin
        e.fwe  = 3'b101;
        e.setb = 1'b1;
        if (b == 0) begin
          e.val = 8'(a);
          e.bo  = 8'(b);
          e.ov  = 1'b1;
        end else begin
          e.val = 8'(a / b);
          e.bo  = 8'(a % b);
          e.lat = 4'd9;
        end
      end
    endcase
    return e;
  endfunction

  // Issue one operation and check its completion; inj>0 pulses a stray DEC
  // start in that cycle of the operation.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cy, input int inj);
    exp_t e;
    int   c, busy_bad, extra;
    bit   seen;
    e = model(int'(op), int'(a), int'(b), int'(cy));
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cy_in = cy;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in  = 8'($urandom);
    bus.b_in  = 8'($urandom);
    bus.cy_in = 1'($urandom);
    c = 1; seen = 0; busy_bad = 0;
    while (!seen && c <= 20) begin
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin
        seen = 1;
      end else begin
        if (c == inj) begin
          bus.start = 1'b1;
          bus.op    = 4'h4;
        end else if (c == inj + 1) begin
          bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        c++;
      end
    end
    if (!seen) begin
      check_val($sformatf("timeout op%0h", op), 32'(c), 32'(e.lat));
      return;
    end
    check_val($sformatf("lat op%0h", op), 32'(c), 32'(e.lat));
    check_val($sformatf("busy op%0h", op), 32'(busy_bad), 32'd0);
    check_val($sformatf("value op%0h a=%0h b=%0h c=%0d", op, a, b, cy), 32'(bus.value), 32'(e.val));
    check_val($sformatf("set_acc op%0h", op), 32'(bus.set_acc), 32'd1);
    check_val($sformatf("set_b op%0h", op), 32'(bus.set_b), 32'(e.setb));
    check_val($sformatf("flag_we op%0h", op), 32'(bus.flag_we), 32'(e.fwe));
    if (e.setb)   check_val($sformatf("b_out op%0h a=%0h b=%0h", op, a, b), 32'(bus.b_out), 32'(e.bo));
    if (e.fwe[2]) check_val($sformatf("cy op%0h a=%0h b=%0h c=%0d", op, a, b, cy), 32'(bus.cy_out), 32'(e.cy));
    if (e.fwe[1]) check_val($sformatf("ac op%0h a=%0h b=%0h c=%0d", op, a, b, cy), 32'(bus.ac_out), 32'(e.ac));
    if (e.fwe[0]) check_val($sformatf("ov op%0h a=%0h b=%0h c=%0d", op, a, b, cy), 32'(bus.ov_out), 32'(e.ov));
    @(posedge clk);
    #1;
    check_val($sformatf("idle_after op%0h", op),
              32'({bus.done, bus.busy, bus.set_acc, bus.set_b, bus.flag_we}), 32'd0);
    check_val($sformatf("hold op%0h", op), 32'(bus.value), 32'(e.val));
    extra = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) extra++;
    end
    check_val($sformatf("extra_done op%0h", op), 32'(extra), 32'd0);
  endtask

  function automatic logic [25:0] out_vec();
    return {bus.busy, bus.done, bus.set_acc, bus.set_b, bus.flag_we,
            bus.value, bus.b_out, bus.cy_out, bus.ac_out, bus.ov_out};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [3:0] rop;
    logic [7:0] ra, rb;
    bus.start = 1'b0;
    bus.op    = 4'h0;
    bus.a_in  = 8'h00;
    bus.b_in  = 8'h00;
    bus.cy_in = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset held with start asserted: nothing may move
    bus.start = 1'b1;
    bus.a_in  = 8'h12;
    bus.b_in  = 8'h34;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("reset_outs", 32'(out_vec()), 32'd0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;

    run_op(4'h0, 8'h7F, 8'h01, 1'b0, 0);
    run_op(4'h2, 8'h00, 8'h01, 1'b1, 0);
    run_op(4'hB, 8'h80, 8'h00, 1'b0, 0);
    run_op(4'hE, 8'h50, 8'hA0, 1'b0, 0);
    run_op(4'hE, 8'h0F, 8'h02, 1'b0, 0);
    run_op(4'hF, 8'hFB, 8'h12, 1'b0, 0);
    run_op(4'hF, 8'h33, 8'h00, 1'b0, 0);
    run_op(4'h3, 8'hFF, 8'h00, 1'b0, 0);
    run_op(4'h4, 8'h00, 8'h00, 1'b0, 0);
    run_op(4'hC, 8'h01, 8'h00, 1'b1, 0);

    // Stray DEC start during a MUL must be ignored
    run_op(4'hE, 8'hC3, 8'h5A, 1'b0, 4);

    // Reset in the middle of a DIV aborts without any strobe
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'hF;
    bus.a_in  = 8'hC8;
    bus.b_in  = 8'h07;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("abort_outs", 32'(out_vec()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
    end
    check_val("abort_no_done", 32'(dones), 32'd0);
    run_op(4'h3, 8'hFF, 8'h00, 1'b0, 0);

    // Randomized operations
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(rop, ra, rb, 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
